// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_pkg
//  Description : Shared AES-128 constants and helpers: the S-box table,
//                xtime() in GF(2^8), the round constant lookup, the on-the-fly
//                key expansion step and the DONE round encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Value the round counter takes once the last round has been written.
  localparam logic [3:0] DONE = 4'd11;

  // S-box, entry 0 in the top byte so entry n lives at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for rounds 1..10; anything else never reaches the datapath.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // One step of the AES-128 key schedule: current round key -> next round key.
  function automatic logic [127:0] key_expand(input logic [127:0] rk,
                                              input logic [7:0]   rc);
    logic [31:0] w3_rot;
    logic [31:0] sub_w;
    logic [31:0] n0, n1, n2, n3;
    w3_rot = {rk[23:0], rk[31:24]};
    sub_w  = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
              sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])};
    n0 = rk[127:96] ^ sub_w ^ {rc, 24'h0};
    n1 = n0 ^ rk[95:64];
    n2 = n1 ^ rk[63:32];
    n3 = n2 ^ rk[31:0];
    return {n0, n1, n2, n3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round
//  Description : Combinational AES round: SubBytes, ShiftRows, MixColumns
//                (skipped on the last round) and AddRoundKey.
//  Revision    : 1.0 - initial release
//  Ports       : state_in   [127:0] in  - current state, byte 0 at bit 127
//                round_key  [127:0] in  - key for this round
//                last_round         in  - 1 bypasses MixColumns
//                state_out  [127:0] out - next state
// ============================================================================
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [7:0] sb [0:15];
  logic [7:0] sr [0:15];
  logic [7:0] mc [0:15];

  // Byte index i = row + 4*column (column-major state).
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    assign sb[i] = sbox(state_in[127-8*i -: 8]);
    // Row r is rotated left by r positions.
    assign sr[i] = sb[ROW + 4*((COL + ROW) % 4)];
    assign state_out[127-8*i -: 8] = (last_round ? sr[i] : mc[i])
                                     ^ round_key[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mixcol
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule
`default_nettype wire

// File: rtl/aes128_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_encrypt
//  Description : Iterative AES-128 encryptor, one round per clock, with the
//                round key expanded alongside the data path.
//  Revision    : 1.0 - initial release
//  Ports       : clk                in  - rising-edge clock
//                start              in  - synchronous load/restart (active high)
//                plaintext  [127:0] in  - block, byte 0 at bit 127
//                key        [127:0] in  - cipher key, same byte order
//                cyphertext [127:0] out - result, valid while state_check == 11
//                state_check  [3:0] out - round counter
//                data_check [127:0] out - working state register
// ============================================================================
module aes128_encrypt
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] cyphertext,
  output logic [3:0]   state_check,
  output logic [127:0] data_check
);

  logic [127:0] data_q, data_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] ct_q, ct_d;

  logic [127:0] next_key;
  logic [127:0] next_data;
  logic         last_round;
  logic         active;

  assign next_key   = key_expand(rk_q, rcon(round_q));
  assign last_round = (round_q == 4'(NR));
  assign active     = (round_q >= 4'd1) && (round_q <= 4'(NR));

  aes_round u_round (
    .state_in   (data_q),
    .round_key  (next_key),
    .last_round (last_round),
    .state_out  (next_data)
  );

  // DONE and illegal counter values fall through to hold.
  always_comb begin
    data_d  = data_q;
    rk_d    = rk_q;
    round_d = round_q;
    ct_d    = ct_q;
    if (start) begin
      data_d  = plaintext ^ key;
      rk_d    = key;
      round_d = 4'd1;
      ct_d    = '0;
    end else if (active) begin
      data_d  = next_data;
      rk_d    = next_key;
      round_d = last_round ? DONE : round_q + 4'd1;
      if (last_round) begin
        ct_d = next_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    data_q  <= data_d;
    rk_q    <= rk_d;
    round_q <= round_d;
    ct_q    <= ct_d;
  end

  assign cyphertext  = ct_q;
  assign state_check = round_q;
  assign data_check  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_encrypt
//  Description : Directed vector bench for aes128_encrypt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_encrypt;

  logic         clk = 1'b0;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] cyphertext;
  logic [3:0]   state_check;
  logic [127:0] data_check;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [4];

  aes128_encrypt dut (
    .clk         (clk),
    .start       (start),
    .plaintext   (plaintext),
    .key         (key),
    .cyphertext  (cyphertext),
    .state_check (state_check),
    .data_check  (data_check)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [127:0] pt, input logic [127:0] k);
    start     = 1'b1;
    plaintext = pt;
    key       = k;
    tick();
    start = 1'b0;
  endtask

  localparam logic [127:0] FIPS_PT = 128'h54776F20_4F6E6520_4E696E65_2054776F;
  localparam logic [127:0] FIPS_K  = 128'h5468_6174_7320_6D79_204B_756E_6720_4675;
  localparam logic [127:0] FIPS_CT = 128'h29C3505F_571420F6_402299B3_1A02D73A;
  localparam logic [127:0] C1_PT   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] C1_K    = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] C1_CT   = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;

  initial begin
    logic [127:0] hold_ct, hold_data;

    vecs[0] = '{FIPS_PT, FIPS_K, FIPS_CT};
    vecs[1] = '{C1_PT, C1_K, C1_CT};
    vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734,
                128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[3] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    tick();

    // Table: load, check round-0 state, run to DONE.
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].pt, vecs[v].key);
      check("load_state", {124'h0, state_check}, 128'd1);
      check("load_ct_zero", cyphertext, 128'h0);
      check("load_data", data_check, vecs[v].pt ^ vecs[v].key);
      for (int c = 0; c < 9; c++) tick();
      check("round10_state", {124'h0, state_check}, 128'd10);
      tick();
      check("done_state", {124'h0, state_check}, 128'd11);
      check("ct", cyphertext, vecs[v].ct);
      check("ct_eq_data", data_check, vecs[v].ct);
    end

    // FIPS example intermediates and round keys.
    load(FIPS_PT, FIPS_K);
    check("r1_data", data_check, 128'h001F0E54_3C4E0859_6E221B0B_4774311A);
    tick();
    check("r2_state", {124'h0, state_check}, 128'd2);
    check("r2_data", data_check, 128'h5847088B_15B61CBA_59D4E2E8_CD39DFCE);
    check("r2_rk", dut.rk_q, 128'hE232FCF1_91129188_B159E4E6_D679A293);
    for (int c = 0; c < 9; c++) tick();
    check("fips_ct", cyphertext, FIPS_CT);
    check("last_rk", dut.rk_q, 128'h28FDDEF8_6DA4244A_CCC0A4FE_3B316F26);

    // Hold in DONE while inputs wander.
    hold_ct   = cyphertext;
    hold_data = data_check;
    for (int c = 0; c < 20; c++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("hold_ct", cyphertext, FIPS_CT);
      check("hold_data", data_check, hold_data);
      check("hold_state", {124'h0, state_check}, 128'd11);
    end

    // Start held for several cycles keeps reloading round 1.
    start = 1'b1; plaintext = C1_PT; key = C1_K;
    tick(); tick(); tick();
    start = 1'b0;
    check("multi_start_state", {124'h0, state_check}, 128'd1);
    check("multi_start_data", data_check, C1_PT ^ C1_K);
    for (int c = 0; c < 10; c++) tick();
    check("multi_start_ct", cyphertext, C1_CT);

    // Abort mid-run: start FIPS, restart with C.1 at round 5.
    load(FIPS_PT, FIPS_K);
    for (int c = 0; c < 4; c++) tick();
    check("abort_pre_state", {124'h0, state_check}, 128'd5);
    load(C1_PT, C1_K);
    check("abort_state", {124'h0, state_check}, 128'd1);
    check("abort_ct_zero", cyphertext, 128'h0);
    plaintext = FIPS_PT;  // ignored during the run
    key       = FIPS_K;
    for (int c = 0; c < 10; c++) tick();
    check("abort_done_state", {124'h0, state_check}, 128'd11);
    check("abort_ct", cyphertext, C1_CT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes128_encrypt.md
Name: aes128_encrypt

Overview:
- Iterative AES-128 encryption core (FIPS-197): one 128-bit block, one 128-bit key, one round per clock.
- Round keys are expanded on the fly, alongside the data path; no key schedule RAM.
- Sits behind a register interface.
- Exposes internal FSM/round state and the working data register as debug outputs.

Parameters:
- NR, 10, number of AES rounds (fixed for AES-128; not intended to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- start  input  1  synchronous, active-high reset-and-load. Sampled only at the rising edge of clk; it is the block's reset.
- plaintext  input  128  input block. Bit 127 is byte 0, in FIPS column-major byte order.
- key  input  128  cipher key, same byte order.
- cyphertext  output  128  result. Registered; valid while state_check == 11.
- state_check  output  4  current round counter / FSM state.
- data_check  output  128  current working state register.

Behaviour:
- Registers:
  - data (128)
  - rk (current round key, 128)
  - round (4)
  - cyphertext (128)
- start=1 at a posedge (reset/load):
  - data <= plaintext ^ key (round-0 AddRoundKey).
  - rk <= key.
  - round <= 1.
  - cyphertext <= 0.
  - start has priority over everything, including mid-encryption, where it aborts and restarts.
- start=0 and 1 <= round <= 10, at each posedge:
  - nk = KeyExpand(rk, rcon[round]), where rcon = 01,02,04,08,10,20,40,80,1B,36.
  - nk word0 = rk.w0 ^ SubWord(RotWord(rk.w3)) ^ {rcon,24'h0}.
  - nk word i = nk.w(i-1) ^ rk.wi, for i = 1..3.
  - data <= AddRoundKey(MixColumns(ShiftRows(SubBytes(data))), nk).
  - MixColumns is omitted when round == 10.
  - rk <= nk.
  - round <= round + 1.
- When round == 10 completes: cyphertext <= the same final value written to data; round becomes 11 (DONE).
- round == 11 (DONE) or an illegal value (0, 12–15) with start=0: all registers hold.
  - A new encryption requires start.
- Outputs:
  - state_check = round.
  - data_check = data.
- Timing and input handling:
  - Latency: cyphertext is valid 10 clocks after the posedge that sampled start=1.
  - plaintext and key are sampled only on start. Changes during a run are ignored.
  - Register contents before the first start are don't-care.
- Arithmetic:
  - All GF(2^8) arithmetic uses xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0).
  - MixColumns per column: [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
- S-box: combinational constant table; 16 instances in the datapath plus 4 in the key expansion.

Decomposition:
- Package aes_pkg:
  - the 256-entry SBOX constant plus an sbox() function
  - xtime() and the RCON constant array
  - the DONE state encoding (4'd11)
- One natural sub-module, aes_round: combinational; inputs state, round key and a last-round flag; output is the next state.
- Key expansion stays inline in the top as a function from aes_pkg.

Test Plan:
- FIPS example: start=1 for one cycle with plaintext=5477_6F20_4F6E_6520_4E69_6E65_2054_776F and key=5468_6174_7320_6D79_204B_756E_6720_4675.
  - Immediately after that edge: data_check = 001F0E54_3C4E0859_6E221B0B_4774311A, state_check = 1.
- Same run, next edge: data_check = 5847088B_15B61CBA_59D4E2E8_CD39DFCE, state_check = 2.
  - Internal rk = E232FCF1_91129188_B159E4E6_D679A293.
- Same run, 10th edge after start:
  - cyphertext = 29C3505F_571420F6_402299B3_1A02D73A.
  - state_check = 11.
  - Last round key = 28FDDEF8_6DA4244A_CCC0A4FE_3B316F26.
- Hold: run 20 further cycles after DONE.
  - cyphertext, data_check and state_check must stay unchanged.
  - Change plaintext/key during this period; outputs must remain unaffected.
- FIPS-197 Appendix C.1: plaintext=00112233_44556677_8899AABB_CCDDEEFF, key=00010203_04050607_08090A0B_0C0D0E0F.
  - Required result: cyphertext = 69C4E0D8_6A7B0430_D8CDB780_70B4C55A after 10 cycles.
- Abort: assert start at state_check=5 with the C.1 vectors.
  - Next cycle: state_check = 1 and cyphertext = 0.
  - 10 cycles after that: cyphertext = 69C4E0D8_6A7B0430_D8CDB780_70B4C55A.
